// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a common-anode seven-segment display.
// Data is double-buffered (shadow -> active) and committed only at a frame wrap,
// so a frame never mixes old and new digits.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned CLK_DIV        = 100000,
    parameter int unsigned BLANK_CYC      = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DW = 4 * NUM_DIGITS;

    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         shadow_d;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [DW-1:0]         active_d;
    logic [NUM_DIGITS-1:0] active_dp;
    logic                  pending;

    logic                  tick_c;
    logic                  wrap_c;
    logic [NUM_DIGITS-1:0] lz_c;
    logic [3:0]            cur_nib_c;
    logic                  cur_dp_c;
    logic                  cur_blank_c;
    logic [NUM_DIGITS-1:0] onehot_c;
    logic [6:0]            pat_c;
    logic [6:0]            seg_nxt_c;
    logic                  dp_nxt_c;
    logic [NUM_DIGITS-1:0] an_nxt_c;

    // Hex nibble to active-low {g,f,e,d,c,b,a} pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Slot tick and frame wrap
    always_comb begin
        tick_c = en && (cnt == CW'(CLK_DIV - 1));
        wrap_c = tick_c && (idx == IW'(NUM_DIGITS - 1));
    end

    // Leading-zero mask: digit k is zero along with every digit above it
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_c     = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            all_zero = all_zero && (active_d[4*k +: 4] == 4'h0);
            lz_c[k]  = all_zero;
        end
        lz_c[0] = 1'b0;
    end

    // Select the digit currently being scanned and build next output values
    always_comb begin
        cur_nib_c   = '0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        onehot_c    = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx == IW'(k)) begin
                cur_nib_c   = active_d[4*k +: 4];
                cur_dp_c    = active_dp[k];
                cur_blank_c = blank_lz && lz_c[k];
                onehot_c[k] = 1'b1;
            end
        end
        pat_c     = hex_to_seg(cur_nib_c);
        seg_nxt_c = cur_blank_c ? SEG_OFF : (SEG_ACTIVE_LOW ? pat_c : ~pat_c);
        dp_nxt_c  = SEG_ACTIVE_LOW ? ~cur_dp_c : cur_dp_c;
        if (en && (cnt >= CW'(BLANK_CYC))) begin
            an_nxt_c = AN_ACTIVE_LOW ? ~onehot_c : onehot_c;
        end else begin
            an_nxt_c = AN_OFF;
        end
    end

    // Prescaler and digit index; both freeze while en=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick_c) begin
            cnt <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow capture and frame-boundary commit; a load coinciding with a wrap bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_d  <= '0;
            shadow_dp <= '0;
            active_d  <= '0;
            active_dp <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                shadow_d  <= din;
                shadow_dp <= dp_in;
            end
            if (wrap_c && load) begin
                active_d  <= din;
                active_dp <= dp_in;
                pending   <= 1'b0;
            end else if (wrap_c && pending) begin
                active_d  <= shadow_d;
                active_dp <= shadow_dp;
                pending   <= 1'b0;
            end else if (load) begin
                pending   <= 1'b1;
            end
        end
    end

    // Registered pin drivers and frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt_c;
            dp         <= dp_nxt_c;
            an         <= an_nxt_c;
            frame_done <= wrap_c;
        end
    end

endmodule
